serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Parametrised, digit-serial multi-bit subtractor built from a chain of `DIGIT` full-subtractor cells with a registered borrow. It computes `D = A - B - Bin` over `WIDTH` bits in `WIDTH/DIGIT` clock cycles under a start/done handshake. It also reports borrow-out, signed overflow and zero flags. It is the sequential, width-generic successor of the single-bit full subtractor and serves as the arithmetic unit for multi-bit datapaths in the project.

## Interface
Parameters:
- `WIDTH`, 8: operand and result width in bits; must be ≥ 2.
- `DIGIT`, 1: bits processed per cycle; must divide `WIDTH` (elaboration error otherwise).

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request a subtraction; sampled only in IDLE.
- `A`, input, WIDTH: minuend; captured on an accepted `start`.
- `B`, input, WIDTH: subtrahend; captured on an accepted `start`.
- `Bin`, input, 1: borrow-in; captured on an accepted `start`.
- `busy`, output, 1: high while the FSM is in RUN.
- `done`, output, 1: one-cycle pulse; high only in DONE.
- `D`, output, WIDTH: registered difference.
- `Bout`, output, 1: borrow out of the MSB.
- `V`, output, 1: signed overflow, equal to the borrow into the MSB XOR the borrow out of the MSB.
- `Z`, output, 1: high when `D == 0`.

## Operation
- Let N = WIDTH/DIGIT. The FSM has three states: IDLE, RUN and DONE.
- IDLE with `start=1`:
  - Load shift registers `a_sh<=A` and `b_sh<=B`.
  - Set the borrow register to `Bin` and the digit counter to 0.
  - Go to RUN.
- IDLE with `start=0`: remain in IDLE.
- RUN, each cycle:
  - The `DIGIT`-cell ripple uses the full-subtractor equations `d=a^b^bi` and `bo=(~a&b)|(~a&bi)|(b&bi)`. It operates on the LSB digit of `a_sh` and `b_sh` plus the borrow register.
  - The result digit shifts into the MSB end of the `d_sh` accumulator. `a_sh` and `b_sh` shift right by `DIGIT`.
  - The borrow register takes the digit's borrow-out. The counter increments.
  - On the last digit (counter = N-1), also record the borrow into bit `WIDTH-1` for `V`.
  - After the last digit, go to DONE.
- Result registers `D`, `Bout`, `V` and `Z` load only on the transition RUN→DONE, and hold until the next completion. Intermediate `d_sh` values are never visible on `D`.
- DONE: `done=1` for one cycle, then unconditionally go to IDLE.
- `start` in RUN or DONE is ignored; no queuing. A `start` held high through DONE is accepted in the following IDLE cycle.
- Input changes on `A`, `B` and `Bin` after capture have no effect on the operation in progress.
- Unsigned interpretation: `Bout=1` iff A < B + Bin.
- Signed interpretation: `V=1` iff the two's-complement result is out of range.

## Timing
- Reset values:
  - State = IDLE.
  - `busy`, `done`, `Bout`, `V` = 0.
  - `D` = 0.
  - `Z` = 1, consistent with D = 0.
  - Internal shift registers and counter = 0.
- Asserting `rst_n` low mid-operation aborts immediately. All outputs return to reset values, and no `done` is issued for the aborted operation.
- `start` sampled high at edge k:
  - `busy=1` from after edge k through edge k+N.
  - After edge k+N: `done=1`, results valid, `busy=0`.
  - After edge k+N+1: IDLE. The earliest next accepted start is edge k+N+2.
- Latency from start to `done` is N+1 edges; throughput is one result per N+2 cycles.
- `done` is a single-cycle pulse; results stay valid and stable after `done` falls.
- With DIGIT = WIDTH (N = 1), the block behaves as a registered parallel subtractor: `done` appears 2 edges after start.

## Test plan
- Basic, WIDTH=8, DIGIT=1: A=0x05, B=0x03, Bin=0 with start → `busy` high for 8 cycles, then D=0x02, Bout=0, V=0, Z=0. `done` pulses exactly one cycle, 9 edges after start.
- Underflow and signed overflow, WIDTH=8, DIGIT=1:
  - A=0x00, B=0x01, Bin=0 → D=0xFF, Bout=1, V=0, Z=0.
  - A=0x80, B=0x01, Bin=0 → D=0x7F, Bout=0, V=1.
- Borrow-in and zero: A=0x10, B=0x0F, Bin=1 → D=0x00, Bout=0, V=0, Z=1. Also A=0x7F, B=0xFF, Bin=0 → D=0x80, Bout=1, V=1.
- Handshake, WIDTH=8, DIGIT=1:
  - Pulse `start` again during RUN, and change A/B/Bin mid-run → result and timing unaffected.
  - Hold `start` high continuously → back-to-back operations, one accepted every 10 cycles.
- Reset mid-run: with WIDTH=8, DIGIT=1, drive `rst_n` low 3 cycles after start → all outputs immediately at reset values (Z=1), no `done`. After release, a new operation A=0x09, B=0x04 → D=0x05.
- Parameter sweep: WIDTH=16 with DIGIT in {1, 4, 16} → `done` 17, 5 and 2 edges after start. Check against a random A−B−Bin reference model (≥1000 vectors each), covering D, Bout, V and Z.

Source files
------------

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: D = A - B - Bin over WIDTH bits, DIGIT bits per clock,
// with a start/done handshake and registered borrow-out, signed-overflow and zero flags.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V,
  output logic             Z
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_subtractor: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] d_sh_q, d_sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] d_res_q, d_res_d;
  logic             bout_q, bout_d;
  logic             v_q, v_d;
  logic             z_q, z_d;

  logic [DIGIT-1:0]       dig;
  logic                   dig_bout;
  logic                   msb_bin;
  logic [WIDTH+DIGIT-1:0] d_cat;
  logic                   last;

  // Ripple of DIGIT full-subtractor cells over the low digit of the shift registers.
  always_comb begin
    logic br;
    br      = br_q;
    msb_bin = 1'b0;
    dig     = '0;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) msb_bin = br;
      dig[i] = a_sh_q[i] ^ b_sh_q[i] ^ br;
      br     = (~a_sh_q[i] & b_sh_q[i]) | (~a_sh_q[i] & br) | (b_sh_q[i] & br);
    end
    dig_bout = br;
  end

  assign d_cat = {dig, d_sh_q};
  assign last  = (cnt_q == CW'(N - 1));

  always_comb begin
    // NOTE: every *_d gets a default first so no path through the case infers a latch.
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    d_sh_d  = d_sh_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    d_res_d = d_res_q;
    bout_d  = bout_q;
    v_d     = v_q;
    z_d     = z_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = A;
          b_sh_d  = B;
          br_d    = Bin;
          cnt_d   = '0;
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> DIGIT;
        b_sh_d = b_sh_q >> DIGIT;
        d_sh_d = d_cat[WIDTH+DIGIT-1:DIGIT];
        br_d   = dig_bout;
        cnt_d  = cnt_q + CW'(1);
        if (last) begin
          // Results are published only here, so partial d_sh never reaches D.
          state_d = DONE;
          done_d  = 1'b1;
          d_res_d = d_sh_d;
          bout_d  = dig_bout;
          v_d     = msb_bin ^ dig_bout;
          z_d     = (d_sh_d == '0);
        end else begin
          busy_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      d_sh_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      d_res_q <= '0;
      bout_q  <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b1;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      d_sh_q  <= d_sh_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      d_res_q <= d_res_d;
      bout_q  <= bout_d;
      v_q     <= v_d;
      z_q     <= z_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign D    = d_res_q;
  assign Bout = bout_q;
  assign V    = v_q;
  assign Z    = z_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: fixed vectors and handshake/reset sequences on an 8-bit
// unit, plus random sweeps of 16-bit units (DIGIT 1, 4, 16) against an arithmetic model.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Unit 0: WIDTH=8 DIGIT=1; units 1..3: WIDTH=16 with DIGIT 1, 4, 16.
  logic [15:0] a_i [4];
  logic [15:0] b_i [4];
  logic        start_i [4];
  logic        bin_i [4];

  logic [7:0]  d8;
  logic [15:0] d16_1, d16_2, d16_3;
  logic [3:0]  busy_v, done_v, bout_v, vv_v, z_v;
  logic [15:0] d_v [4];

  always_comb begin
    d_v[0] = {8'h00, d8};
    d_v[1] = d16_1;
    d_v[2] = d16_2;
    d_v[3] = d16_3;
  end

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_i[0]), .A(a_i[0][7:0]), .B(b_i[0][7:0]),
    .Bin(bin_i[0]), .busy(busy_v[0]), .done(done_v[0]), .D(d8), .Bout(bout_v[0]),
    .V(vv_v[0]), .Z(z_v[0]));
  serial_subtractor #(.WIDTH(16), .DIGIT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_i[1]), .A(a_i[1]), .B(b_i[1]),
    .Bin(bin_i[1]), .busy(busy_v[1]), .done(done_v[1]), .D(d16_1), .Bout(bout_v[1]),
    .V(vv_v[1]), .Z(z_v[1]));
  serial_subtractor #(.WIDTH(16), .DIGIT(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_i[2]), .A(a_i[2]), .B(b_i[2]),
    .Bin(bin_i[2]), .busy(busy_v[2]), .done(done_v[2]), .D(d16_2), .Bout(bout_v[2]),
    .V(vv_v[2]), .Z(z_v[2]));
  serial_subtractor #(.WIDTH(16), .DIGIT(16)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start_i[3]), .A(a_i[3]), .B(b_i[3]),
    .Bin(bin_i[3]), .busy(busy_v[3]), .done(done_v[3]), .D(d16_3), .Bout(bout_v[3]),
    .V(vv_v[3]), .Z(z_v[3]));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic int width_of(int u);
    return (u == 0) ? 8 : 16;
  endfunction

  function automatic int digits_of(int u);
    case (u)
      0:       return 8;
      1:       return 16;
      2:       return 4;
      default: return 1;
    endcase
  endfunction

  // Plain-arithmetic reference: unsigned and signed views of A - B - Bin.
  task automatic model(input int w, input logic [15:0] a, input logic [15:0] b, input logic bin,
                       output logic [15:0] d, output logic bo, output logic v, output logic z);
    longint mask, half, ua, ub, sa, sb, diff, sres;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    diff = ua - ub - longint'(bin);
    d    = 16'(diff & mask);
    bo   = (diff < 0);
    sa   = (ua >= half) ? ua - (mask + 1) : ua;
    sb   = (ub >= half) ? ub - (mask + 1) : ub;
    sres = sa - sb - longint'(bin);
    v    = (sres < -half) || (sres > half - 1);
    z    = ((diff & mask) == 0);
  endtask

  // Starts one operation (caller is #1 after a rising edge with the unit idle), checks busy
  // every cycle, done latency, results, and that done falls while results hold.
  task automatic do_op(input int u, input logic [15:0] a, input logic [15:0] b, input logic bin,
                       input logic [15:0] ed, input logic eb, input logic ev, input logic ez,
                       input bit disturb);
    int cyc;
    a_i[u] = a; b_i[u] = b; bin_i[u] = bin; start_i[u] = 1'b1;
    @(posedge clk); #1;
    start_i[u] = 1'b0;
    cyc = 0;
    while (!done_v[u] && cyc < 40) begin
      check($sformatf("busy_u%0d_c%0d", u, cyc), busy_v[u], 1'b1);
      @(posedge clk); #1;
      cyc++;
      if (disturb && cyc == 2) begin
        start_i[u] = 1'b1; a_i[u] = ~a; b_i[u] = ~b; bin_i[u] = ~bin;
      end
      if (disturb && cyc == 3) start_i[u] = 1'b0;
    end
    check($sformatf("latency_u%0d", u), cyc, digits_of(u));
    check($sformatf("busy_at_done_u%0d", u), busy_v[u], 1'b0);
    check($sformatf("D_u%0d a=%h b=%h bi=%b", u, a, b, bin), d_v[u], ed);
    check($sformatf("Bout_u%0d a=%h b=%h bi=%b", u, a, b, bin), bout_v[u], eb);
    check($sformatf("V_u%0d a=%h b=%h bi=%b", u, a, b, bin), vv_v[u], ev);
    check($sformatf("Z_u%0d a=%h b=%h bi=%b", u, a, b, bin), z_v[u], ez);
    @(posedge clk); #1;
    check($sformatf("done_pulse_u%0d", u), done_v[u], 1'b0);
    check($sformatf("D_hold_u%0d", u), d_v[u], ed);
  endtask

  typedef struct {
    logic [15:0] a, b;
    logic        bin;
    logic [15:0] d;
    logic        bout, v, z;
  } vec_t;

  initial begin
    vec_t        vecs [5];
    logic [15:0] ed, ra, rb;
    logic        eb, ev, ez, rbin, seen_done;
    int          done_at [$];

    for (int u = 0; u < 4; u++) begin
      a_i[u] = '0; b_i[u] = '0; bin_i[u] = 1'b0; start_i[u] = 1'b0;
    end

    vecs[0] = '{16'h05, 16'h03, 1'b0, 16'h02, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h00, 16'h01, 1'b0, 16'hFF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{16'h80, 16'h01, 1'b0, 16'h7F, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{16'h10, 16'h0F, 1'b1, 16'h00, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{16'h7F, 16'hFF, 1'b0, 16'h80, 1'b1, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 4; u++) begin
      check($sformatf("rst_busy_u%0d", u), busy_v[u], 1'b0);
      check($sformatf("rst_done_u%0d", u), done_v[u], 1'b0);
      check($sformatf("rst_D_u%0d", u), d_v[u], 16'h0);
      check($sformatf("rst_Bout_u%0d", u), bout_v[u], 1'b0);
      check($sformatf("rst_V_u%0d", u), vv_v[u], 1'b0);
      check($sformatf("rst_Z_u%0d", u), z_v[u], 1'b1);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++)
      do_op(0, vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d, vecs[i].bout, vecs[i].v, vecs[i].z, 1'b0);

    // start pulsed and operands changed mid-run must not disturb the result or timing
    do_op(0, 16'h05, 16'h03, 1'b0, 16'h02, 1'b0, 1'b0, 1'b0, 1'b1);
    do_op(0, 16'h80, 16'h01, 1'b0, 16'h7F, 1'b0, 1'b1, 1'b0, 1'b1);

    // Reset three cycles into a run, after a result with every flag non-default.
    do_op(0, 16'h7F, 16'hFF, 1'b0, 16'h80, 1'b1, 1'b1, 1'b0, 1'b0);
    a_i[0] = 16'h33; b_i[0] = 16'h11; bin_i[0] = 1'b0; start_i[0] = 1'b1;
    @(posedge clk); #1;
    start_i[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy_v[0], 1'b0);
    check("midrst_D", d_v[0], 16'h0);
    check("midrst_Bout", bout_v[0], 1'b0);
    check("midrst_V", vv_v[0], 1'b0);
    check("midrst_Z", z_v[0], 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done_v[0]) seen_done = 1'b1;
    end
    check("midrst_no_done", seen_done, 1'b0);
    do_op(0, 16'h09, 16'h04, 1'b0, 16'h05, 1'b0, 1'b0, 1'b0, 1'b0);

    // start held high: one accepted every N+2 = 10 cycles.
    a_i[0] = 16'h05; b_i[0] = 16'h03; bin_i[0] = 1'b0; start_i[0] = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk); #1;
      if (done_v[0]) begin
        done_at.push_back(c);
        check($sformatf("b2b_D_c%0d", c), d_v[0], 16'h02);
      end
    end
    start_i[0] = 1'b0;
    check("b2b_count", done_at.size(), 4);
    for (int i = 0; i < done_at.size(); i++)
      check($sformatf("b2b_done_edge%0d", i), done_at[i], 9 + 10 * i);
    repeat (12) @(posedge clk);
    #1;

    // Random sweep against the arithmetic model.
    for (int u = 0; u < 4; u++) begin
      for (int i = 0; i < ((u == 0) ? 200 : 1000); i++) begin
        ra   = 16'($urandom);
        rb   = 16'($urandom);
        rbin = 1'($urandom);
        if (u == 0) begin
          ra[15:8] = 8'h00;
          rb[15:8] = 8'h00;
        end
        if (i % 50 == 0) rb = ra;
        model(width_of(u), ra, rb, rbin, ed, eb, ev, ez);
        do_op(u, ra, rb, rbin, ed, eb, ev, ez, 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
